// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: FSM states, melody entry
// layout, duration decode and default tick rate.
package melody_sequencer_pkg;

  // 16 ticks per second at 50 MHz.
  localparam int DEFAULT_TICK_CYC = 3125000;

  localparam int ADDR_W  = 6;
  localparam int ENTRY_W = 8;
  localparam int NOTE_W  = 16;

  // Entry layout: [7] end marker, [6] rest, [5:2] pitch, [1:0] duration code.
  localparam int END_BIT   = 7;
  localparam int REST_BIT  = 6;
  localparam int PITCH_LSB = 2;
  localparam int PITCH_W   = 4;
  localparam int DUR_LSB   = 0;
  localparam int DUR_W     = 2;

  // Raw value used for addresses past the end of the table: an end marker.
  localparam logic [ENTRY_W-1:0] END_ENTRY = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  typedef struct packed {
    logic               end_mark;
    logic               rest;
    logic [PITCH_W-1:0] pitch;
    logic [DUR_W-1:0]   dur;
  } entry_t;

  // Split a raw ROM byte into its fields.
  function automatic entry_t decode_entry(input logic [ENTRY_W-1:0] raw);
    entry_t e;
    e.end_mark = raw[END_BIT];
    e.rest     = raw[REST_BIT];
    e.pitch    = raw[PITCH_LSB +: PITCH_W];
    e.dur      = raw[DUR_LSB +: DUR_W];
    return e;
  endfunction

  // Duration code d means 2^d ticks (1, 2, 4 or 8).
  function automatic logic [3:0] dur_ticks(input logic [DUR_W-1:0] d);
    return 4'd1 << d;
  endfunction

  // One-hot pitch select for the tone generator.
  function automatic logic [NOTE_W-1:0] pitch_onehot(input logic [PITCH_W-1:0] p);
    return 16'd1 << p;
  endfunction

endpackage

// File: rtl/melody_sequencer_rom.sv
// Melody table with a combinational read port. The melody is baked in at
// elaboration from the packed init image (entry 0 in the low byte), which is
// generated from the melody init file.
module melody_rom
  import melody_sequencer_pkg::*;
#(
  parameter int                             ROM_DEPTH  = 64,
  parameter logic [ROM_DEPTH*ENTRY_W-1:0]   INIT_IMAGE = {ROM_DEPTH{END_ENTRY}}
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  logic [ENTRY_W-1:0] mem [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_mem
    assign mem[i] = INIT_IMAGE[i*ENTRY_W +: ENTRY_W];
  end

  // Combinational read; anything past the table reads as an end marker.
  always_comb begin
    entry = END_ENTRY;
    if (int'(addr) < ROM_DEPTH) entry = mem[addr];
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the melody ROM, holds each note for 2^d ticks,
// inserts one silent gap tick after every entry, and drives a one-hot pitch
// select to the tone generator. Supports pause, stop, and looping.
//
// Control semantics: start and stop are single-cycle pulses sampled on the
// rising clock edge; stop has priority over everything (including start and
// pause). pause is a level that freezes the playback states and silences
// note_sw combinationally while high. loop is only consulted when the melody
// ends (end marker loaded, or gap finished on the last ROM address).
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int                           TICK_CYC  = DEFAULT_TICK_CYC,
  parameter int                           ROM_DEPTH = 64,
  parameter logic [ROM_DEPTH*ENTRY_W-1:0] ROM_INIT  = {ROM_DEPTH{END_ENTRY}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  output logic [NOTE_W-1:0] note_sw,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output state_t            dbg_state
);

  localparam int                TICK_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [2:0]          dur_cnt;
  logic [DUR_W-1:0]    dur_q;
  logic [NOTE_W-1:0]   note_q;
  logic [ENTRY_W-1:0]  rom_raw;
  entry_t              rom_entry;
  logic                tick;
  logic                dur_end;

  melody_rom #(
    .ROM_DEPTH  (ROM_DEPTH),
    .INIT_IMAGE (ROM_INIT)
  ) u_rom (
    .addr  (addr),
    .entry (rom_raw)
  );

  assign rom_entry = decode_entry(rom_raw);

  // Terminal count of the tick divider; only acted on in PLAY/GAP when not paused.
  assign tick    = (tick_cnt == TICK_LAST);
  // Current tick is the last one of the note.
  assign dur_end = ({1'b0, dur_cnt} == (dur_ticks(dur_q) - 4'd1));

  // Sequencer FSM with tick and duration counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      dur_q    <= '0;
      note_q   <= '0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= S_IDLE;
      addr     <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      note_q   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr  <= '0;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (!pause) begin
            if (rom_entry.end_mark) begin
              if (loop) begin
                addr <= '0;
              end else begin
                state <= S_FIN;
                done  <= 1'b1;
              end
            end else begin
              state    <= S_PLAY;
              tick_cnt <= '0;
              dur_cnt  <= '0;
              dur_q    <= rom_entry.dur;
              note_q   <= rom_entry.rest ? '0 : pitch_onehot(rom_entry.pitch);
            end
          end
        end

        S_PLAY: begin
          if (!pause) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              if (dur_end) begin
                state  <= S_GAP;
                note_q <= '0;
              end else begin
                dur_cnt <= dur_cnt + 3'd1;
              end
            end
          end
        end

        S_GAP: begin
          if (!pause) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              if (addr == LAST_ADDR) begin
                if (loop) begin
                  addr  <= '0;
                  state <= S_LOAD;
                end else begin
                  state <= S_FIN;
                  done  <= 1'b1;
                end
              end else begin
                addr  <= addr + 1'b1;
                state <= S_LOAD;
              end
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign playing   = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
  assign note_sw   = pause ? '0 : note_q;
  assign dbg_state = state;

endmodule
